// File: rtl/serv_pkg.sv
// Shared types and constants for the serial immediate-decode sequencer.
package serv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned WB_LSB = 7;
  localparam int unsigned WB_W   = XLEN - WB_LSB;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned EN_W   = 4;
  localparam int unsigned CTRL_W = 4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(31);
  localparam logic [CNT_W-1:0] U_LO_CNT = CNT_W'(12);

  // Major opcode field, instruction bits [6:2]
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ARMED = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_CSRI = 3'd5
  } imm_type_t;

  typedef struct packed {
    imm_type_t         typ;
    logic [EN_W-1:0]   en;
    logic [CTRL_W-1:0] ctrl;
    logic              csr_imm;
    logic              illegal;
  } decode_t;

endpackage

// File: rtl/serv_immdec_seq_if.sv
// Instruction-bus capture and immediate-decoder load path.
interface serv_immdec_seq_if;
  logic                                      i_ibus_ack;
  logic [serv_pkg::XLEN-1:0]                 i_ibus_rdt;
  logic                                      o_wb_en;
  logic [serv_pkg::WB_W-1:0]                 o_wb_rdt;

  modport master (output i_ibus_ack, output i_ibus_rdt,
                   input  o_wb_en,    input  o_wb_rdt);
  modport slave  (input  i_ibus_ack, input  i_ibus_rdt,
                   output o_wb_en,    output o_wb_rdt);
endinterface

// File: rtl/serv_imm_type_dec.sv
// Opcode/funct3 to immediate type and decoder control lines.
module serv_imm_type_dec
  import serv_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  input  logic             i_funct3_msb,
  output decode_t          o_dec
);

  imm_type_t w_typ;
  logic      w_illegal;

  // Classify major opcode; compressed/reserved encodings are illegal
  always_comb begin
    w_typ     = IMM_I;
    w_illegal = 1'b0;
    case (i_opcode[6:2])
      OP_LOAD, OP_OPIMM, OP_JALR: w_typ = IMM_I;
      OP_SYSTEM:                  w_typ = i_funct3_msb ? IMM_CSRI : IMM_I;
      OP_STORE:                   w_typ = IMM_S;
      OP_BRANCH:                  w_typ = IMM_B;
      OP_LUI, OP_AUIPC:           w_typ = IMM_U;
      OP_JAL:                     w_typ = IMM_J;
      default:                    w_illegal = 1'b1;
    endcase
    if (i_opcode[1:0] != 2'b11) w_illegal = 1'b1;
  end

  always_comb begin
    o_dec         = '0;
    o_dec.typ     = w_typ;
    o_dec.illegal = w_illegal;
    if (!w_illegal) begin
      case (w_typ)
        IMM_I:    begin o_dec.en = 4'b1100; o_dec.ctrl = 4'b0010; end
        IMM_S:    begin o_dec.en = 4'b1001; o_dec.ctrl = 4'b0011; end
        IMM_B:    begin o_dec.en = 4'b1001; o_dec.ctrl = 4'b0101; end
        IMM_U:    begin o_dec.en = 4'b1110; o_dec.ctrl = 4'b1000; end
        IMM_J:    begin o_dec.en = 4'b1110; o_dec.ctrl = 4'b1000; end
        IMM_CSRI: begin o_dec.en = 4'b0010; o_dec.csr_imm = 1'b1; end
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/serv_immdec_seq.sv
// Captures an instruction, classifies its immediate, then sequences 32 serial bit counts.
module serv_immdec_seq
  import serv_pkg::*;
#(
  parameter bit AUTO_GO = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  serv_immdec_seq_if.slave  bus,
  input  logic              i_go,
  input  logic              i_stall,
  output logic              o_cnt_en,
  output logic              o_cnt_done,
  output logic [CNT_W-1:0]  o_cnt,
  output logic [EN_W-1:0]   o_immdec_en,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_csr_imm_en,
  output logic              o_lo_zero,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_illegal,
  output logic              o_err
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [XLEN-1:0]  r_ir;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  decode_t          w_dec;

  serv_imm_type_dec u_dec (
    .i_opcode     (r_ir[OPC_W-1:0]),
    .i_funct3_msb (r_ir[14]),
    .o_dec        (w_dec)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.i_ibus_ack) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = w_dec.illegal ? ST_IDLE : ST_ARMED;
      ST_ARMED: if (i_go || AUTO_GO) w_state_nxt = ST_RUN;
      ST_RUN:   if (o_cnt_done) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decode from state; decoder controls are held for the whole transaction
  always_comb begin
    o_busy       = 1'b0;
    bus.o_wb_en  = 1'b0;
    o_illegal    = 1'b0;
    o_done       = 1'b0;
    o_cnt_en     = 1'b0;
    o_cnt_done   = 1'b0;
    o_lo_zero    = 1'b0;
    o_immdec_en  = '0;
    o_ctrl       = '0;
    o_csr_imm_en = 1'b0;
    if (r_state != ST_IDLE) begin
      o_busy       = 1'b1;
      o_immdec_en  = w_dec.en;
      o_ctrl       = w_dec.ctrl;
      o_csr_imm_en = w_dec.csr_imm;
    end
    case (r_state)
      ST_LOAD: begin
        bus.o_wb_en = 1'b1;
        o_illegal   = w_dec.illegal;
      end
      ST_RUN: begin
        o_cnt_en   = !i_stall;
        o_cnt_done = !i_stall && (r_cnt == CNT_LAST);
        o_lo_zero  = (w_dec.typ == IMM_U) && (r_cnt < U_LO_CNT);
      end
      ST_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ir  <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && bus.i_ibus_ack) r_ir <= bus.i_ibus_rdt;
      // Clearing in ARMED guarantees the count starts at 0 on every RUN entry
      if (r_state == ST_ARMED)  r_cnt <= '0;
      else if (o_cnt_en)        r_cnt <= r_cnt + CNT_W'(1);
      r_err <= o_busy && bus.i_ibus_ack;
    end
  end

  assign bus.o_wb_rdt = r_ir[XLEN-1:WB_LSB];
  assign o_cnt        = r_cnt;
  assign o_err        = r_err;

endmodule

// File: doc/serv_immdec_seq.md
SERV_IMMDEC_SEQ -- requirements
Module: serv_immdec_seq

Interface
REQ-001 SHALL have parameter AUTO_GO, default 0; 1 = enter RUN from ARMED without waiting for i_go.
REQ-002 SHALL have port i_clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_ibus_ack  in  1  instruction word valid this cycle.
REQ-005 SHALL have port i_ibus_rdt  in  32  instruction word.
REQ-006 SHALL have port i_go  in  1  execute stage ready to consume immediate bits.
REQ-007 SHALL have port i_stall  in  1  pause serial counting.
REQ-008 SHALL have port o_wb_en  out  1  load strobe to immediate decoder.
REQ-009 SHALL have port o_wb_rdt  out  25  registered instruction bits [31:7].
REQ-010 SHALL have port o_cnt_en  out  1  serial bit advance.
REQ-011 SHALL have port o_cnt_done  out  1  last serial bit (count 31).
REQ-012 SHALL have port o_cnt  out  5  current bit index.
REQ-013 SHALL have ports o_immdec_en (out, 4) and o_ctrl (out, 4), immediate decoder controls.
REQ-014 SHALL have port o_csr_imm_en  out  1  zero-extended CSR immediate.
REQ-015 SHALL have port o_lo_zero  out  1  force immediate bit to 0 (U-type, counts 0-11).
REQ-016 SHALL have ports o_busy, o_done, o_illegal, o_err (out, 1 each), status.

Function
REQ-017 SHALL implement states IDLE, LOAD, ARMED, RUN, DONE; o_busy = state != IDLE.
REQ-018 IDLE + i_ibus_ack SHALL capture i_ibus_rdt and go to LOAD next cycle.
REQ-019 LOAD SHALL assert o_wb_en exactly one cycle with o_wb_rdt = captured [31:7].
REQ-020 Decode on opcode[6:2] SHALL set {o_immdec_en, o_ctrl}:
 - I (00000, 00100, 11001; 11100 with funct3[2]=0): 1100, 0010.
 - S (01000): 1001, 0011.
 - B (11000): 1001, 0101.
 - U (01101, 00101): 1110, 1000.
 - J (11011): 1110, 1000.
 - CSR-imm (11100 with funct3[2]=1): 0010, 0000, o_csr_imm_en=1.
REQ-021 Any other opcode, or opcode[1:0] != 11, SHALL pulse o_illegal one cycle in LOAD; next state IDLE, no RUN.
REQ-022 LOAD SHALL go to ARMED when legal; ARMED -> RUN when i_go=1 or AUTO_GO=1.
REQ-023 In RUN: o_cnt_en = !i_stall; o_cnt increments only when o_cnt_en=1; o_cnt resets to 0 on RUN entry.
REQ-024 o_cnt_done SHALL equal o_cnt_en & (o_cnt==31); the next state after that cycle is DONE.
REQ-025 DONE SHALL pulse o_done one cycle, then return to IDLE.
REQ-026 o_immdec_en, o_ctrl, o_csr_imm_en SHALL hold decoded values from LOAD through DONE and be 0 in IDLE.
REQ-027 o_lo_zero SHALL be 1 in RUN for U-type while o_cnt<12, else 0.
REQ-028 i_ibus_ack while o_busy=1 SHALL be ignored and pulse o_err the following cycle; DONE+ack is also ignored.
REQ-029 i_go outside ARMED SHALL have no effect; i_stall outside RUN SHALL have no effect.
REQ-030 Exactly 32 o_cnt_en cycles SHALL occur per legal instruction regardless of stall pattern.

Reset
REQ-031 i_rst_n=0 SHALL immediately force state IDLE, o_cnt=0, and all outputs 0, including mid-RUN.
REQ-032 After reset release, the first i_ibus_ack SHALL be accepted normally.

Structure
REQ-033 The package serv_pkg SHALL hold the state enum, opcode constants, and the immediate-type enum {I, S, B, U, J, CSRI}.
REQ-034 A combinational sub-module serv_imm_type_dec (opcode/funct3 -> type, en, ctrl, illegal) SHALL be instantiated once.

Verification
REQ-035 Scenario: ack with 0x00500093 (addi), AUTO_GO=0, i_go at cycle 5 -> o_wb_en at cycle 1; en=1100, ctrl=0010; 32 o_cnt_en cycles; o_done one cycle after o_cnt_done.
REQ-036 Scenario: sw 0x00112623 with i_stall toggled every other RUN cycle -> en=1001, ctrl=0011; still exactly 32 o_cnt_en; o_cnt 0..31 monotonic.
REQ-037 Scenario: lui 0x123450B7 -> en=1110, ctrl=1000; o_lo_zero=1 for counts 0-11 and 0 for counts 12-31.
REQ-038 Scenario: opcode 0x0000007F -> o_illegal pulse in LOAD, no o_cnt_en, back to IDLE; a second ack during ARMED -> o_err pulse, first instruction unaffected.
REQ-039 Scenario: i_rst_n low at o_cnt=17 -> all outputs 0 asynchronously; after release, csrrwi 0x3400D073 runs with o_csr_imm_en=1, en=0010.
